// File: rtl/moore_pkg.sv
// Shared encodings for the serial Moore engine and its scheduler.
// Engine states S0..S3 and controller states IDLE/SHIFT/DONE.
package moore_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } eng_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } ctl_state_t;

endpackage

// File: rtl/moore_engine.sv
// Bit-serial Moore FSM: advances on step, clr forces S0.
// Ports: clk, rst, clr, step, x -> y (S0/S2), state[1:0].
module moore_engine
  import moore_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step,
  input  logic       x,
  output logic       y,
  output logic [1:0] state
);

  eng_state_t st;
  eng_state_t nxt;

  always_comb begin
    nxt = st;
    unique case (st)
      S0, S2:  nxt = x ? S0 : S1;
      S1, S3:  nxt = x ? S2 : S3;
      default: nxt = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S0;
    end else if (clr) begin
      st <= S0;
    end else if (step) begin
      st <= nxt;
    end
  end

  assign y     = (st == S0) || (st == S2);
  assign state = st;

endmodule

// File: rtl/moore_sched.sv
// Round-robin scheduler sharing one serial Moore engine among N clients.
// Ports: req/data_in in; gnt, busy, done, result, final_state out.
// Define MOORE_SCHED_MSB_FIRST_EN to shift words MSB first.
module moore_sched
  import moore_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic [1:0]     final_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(W + 1);

  ctl_state_t      state;
  ctl_state_t      state_n;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [W-1:0]    shreg;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cap_idx;
  logic [W-1:0]    res_n;
  logic [PW-1:0]   pick_idx;
  logic            pick_ok;
  logic            clr;
  logic            step;
  logic            x;
  logic            y;
  logic [1:0]      eng_st;
  int              rr_i;

  moore_engine u_eng (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .step  (step),
    .x     (x),
    .y     (y),
    .state (eng_st)
  );

  // Scan downward so the closest set bit above ptr wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    rr_i     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      rr_i = (int'(ptr) + k) % N;
      if (req[PW'(rr_i)]) begin
        pick_ok  = 1'b1;
        pick_idx = PW'(rr_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // cnt==W is the extra cycle that captures y for the last bit.
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    step    = 1'b0;
    x       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_n = SHIFT;
          clr     = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CW'(W)) begin
          state_n = DONE;
        end else begin
          step = 1'b1;
`ifdef MOORE_SCHED_MSB_FIRST_EN
          x = shreg[W-1];
`else
          x = shreg[0];
`endif
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // y lags its bit by one cycle, so cnt points one past it.
`ifdef MOORE_SCHED_MSB_FIRST_EN
  assign cap_idx = CW'(W) - cnt;
`else
  assign cap_idx = cnt - CW'(1);
`endif

  always_comb begin
    res_n = result;
    if (state == SHIFT && cnt != '0) begin
      for (int i = 0; i < W; i++) begin
        if (cap_idx == CW'(i)) begin
          res_n[i] = y;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      win    <= '0;
      gnt    <= '0;
      shreg  <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            win <= pick_idx;
            cnt <= '0;
            for (int k = 0; k < N; k++) begin
              gnt[k] <= (pick_idx == PW'(k));
              if (pick_idx == PW'(k)) begin
                shreg <= data_in[k*W +: W];
              end
            end
          end
        end
        SHIFT: begin
          cnt    <= cnt + CW'(1);
          result <= res_n;
          if (step) begin
`ifdef MOORE_SCHED_MSB_FIRST_EN
            shreg <= shreg << 1;
`else
            shreg <= shreg >> 1;
`endif
          end
        end
        DONE: begin
          gnt <= '0;
          ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
        default: gnt <= '0;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign final_state = eng_st;

endmodule

// File: tb/tb_moore_sched.sv
// Directed self-checking bench for moore_sched (N=4, W=8).
// Checks reset, latency, results, round-robin, abort and drop.
module tb_moore_sched;

  localparam int N = 4;
  localparam int W = 8;

`ifdef MOORE_SCHED_MSB_FIRST_EN
  localparam logic [1:0] FS_7F = 2'b00;
`else
  localparam logic [1:0] FS_7F = 2'b01;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic [1:0]     final_state;

  int total = 0;
  int bad   = 0;
  int two_hot = 0;

  moore_sched #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .gnt         (gnt),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .final_state (final_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(gnt) > 1) two_hot++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    data_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (done) break;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (gnt !== 4'b0000) begin
      bad++;
      $display("FAIL reset_gnt got=%b want=0000", gnt);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_done got=%b%b want=00", busy, done);
    end
    total++;
    if (result !== 8'h00 || final_state !== 2'b00) begin
      bad++;
      $display("FAIL reset_res got=%h/%b want=00/00",
               result, final_state);
    end
  endtask

  task automatic test_single(input int k, input logic [7:0] w,
                             input logic [1:0] fs);
    logic [N-1:0] oh;
    int n;
    oh = N'(1) << k;
    data_in[k*W +: W] = w;
    req = oh;
    tick();
    total++;
    if (gnt !== oh || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_gnt w=%h got=%b/%b want=%b/1",
               w, gnt, busy, oh);
    end
    wait_done(n);
    total++;
    if (n + 1 !== 10) begin
      bad++;
      $display("FAIL single_lat w=%h got=%0d want=10", w, n + 1);
    end
    total++;
    if (result !== w) begin
      bad++;
      $display("FAIL single_res got=%h want=%h", result, w);
    end
    total++;
    if (final_state !== fs) begin
      bad++;
      $display("FAIL single_fs w=%h got=%b want=%b",
               w, final_state, fs);
    end
    total++;
    if (gnt !== oh) begin
      bad++;
      $display("FAIL single_gnt_done got=%b want=%b", gnt, oh);
    end
    req = '0;
    tick();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_end got=%b/%b/%b want=0000/0/0",
               gnt, busy, done);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] words [4];
    logic [N-1:0] oh;
    int n;
    int exp_k;
    words[0] = 8'h3C;
    words[1] = 8'hC3;
    words[2] = 8'h5A;
    words[3] = 8'h96;
    do_reset();
    two_hot = 0;
    for (int k = 0; k < N; k++) data_in[k*W +: W] = words[k];
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      exp_k = s % N;
      oh = N'(1) << exp_k;
      for (int i = 0; i < 20 && gnt == '0; i++) tick();
      total++;
      if (gnt !== oh) begin
        bad++;
        $display("FAIL rr_order s=%0d got=%b want=%b", s, gnt, oh);
      end
      wait_done(n);
      total++;
      if (result !== words[exp_k]) begin
        bad++;
        $display("FAIL rr_res s=%0d got=%h want=%h",
                 s, result, words[exp_k]);
      end
      tick();
      total++;
      if (done !== 1'b0 || gnt !== 4'b0000) begin
        bad++;
        $display("FAIL rr_pulse s=%0d got=%b/%b want=0/0000",
                 s, done, gnt);
      end
    end
    total++;
    if (two_hot !== 0) begin
      bad++;
      $display("FAIL rr_two_hot got=%0d want=0", two_hot);
    end
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    data_in[2*W +: W] = 8'h81;
    req = 4'b0100;
    wait_done(n);
    wait_done(n);
    total++;
    if (n !== W + 3) begin
      bad++;
      $display("FAIL b2b_period got=%0d want=%0d", n, W + 3);
    end
    total++;
    if (result !== 8'h81 || final_state !== 2'b10) begin
      bad++;
      $display("FAIL b2b_res got=%h/%b want=81/10",
               result, final_state);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    data_in[2*W +: W] = 8'h11;
    req = 4'b0100;
    wait_done(n);
    req = '0;
    tick();
    data_in[0*W +: W] = 8'h6E;
    data_in[3*W +: W] = 8'hE6;
    req = 4'b1001;
    tick();
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL abort_pre_gnt got=%b want=1000", gnt);
    end
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear got=%b/%b/%b want=0000/0/0",
               gnt, busy, done);
    end
    total++;
    if (result !== 8'h00 || final_state !== 2'b00) begin
      bad++;
      $display("FAIL abort_res got=%h/%b want=00/00",
               result, final_state);
    end
    rst = 1'b0;
    tick();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL abort_ptr got=%b want=0001", gnt);
    end
    wait_done(n);
    total++;
    if (n !== W + 1 || result !== 8'h6E) begin
      bad++;
      $display("FAIL abort_next got=%0d/%h want=%0d/6e",
               n, result, W + 1);
    end
    req = '0;
    tick();
  endtask

  task automatic test_drop();
    int n;
    do_reset();
    data_in[1*W +: W] = 8'hA5;
    req = 4'b0010;
    tick();
    tick();
    tick();
    req = '0;
    data_in[1*W +: W] = 8'h3C;
    wait_done(n);
    total++;
    if (n + 3 !== 10) begin
      bad++;
      $display("FAIL drop_lat got=%0d want=10", n + 3);
    end
    total++;
    if (result !== 8'hA5 || final_state !== 2'b10) begin
      bad++;
      $display("FAIL drop_res got=%h/%b want=a5/10",
               result, final_state);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle got=%b want=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single(1, 8'hA5, 2'b10);
    test_single(0, 8'hFF, 2'b00);
    test_single(3, 8'h00, 2'b11);
    test_single(2, 8'h7F, FS_7F);
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
